// File: rtl/axi_line_master.sv
// Cache-line AXI4 burst master: INCR read refill or write-back. Refill responds T+LINE_WORDS+2, write-back T+LINE_WORDS+3.
// One transaction in flight; req_ready only in IDLE; every AXI channel honours slave stalls and bursts always run to completion.
module axi_line_master #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic                     req_we_i,
  input  logic [ADDR_WIDTH-1:0]    req_addr_i,
  input  logic [LINE_WORDS*32-1:0] req_wdata_i,
  output logic                     resp_valid_o,
  output logic [LINE_WORDS*32-1:0] resp_rdata_o,
  output logic                     resp_err_o,
  output logic [ADDR_WIDTH-1:0]    m_axi_araddr,
  output logic [7:0]               m_axi_arlen,
  output logic [2:0]               m_axi_arsize,
  output logic [1:0]               m_axi_arburst,
  output logic                     m_axi_arvalid,
  input  logic                     m_axi_arready,
  input  logic [31:0]              m_axi_rdata,
  input  logic [1:0]               m_axi_rresp,
  input  logic                     m_axi_rlast,
  input  logic                     m_axi_rvalid,
  output logic                     m_axi_rready,
  output logic [ADDR_WIDTH-1:0]    m_axi_awaddr,
  output logic [7:0]               m_axi_awlen,
  output logic [2:0]               m_axi_awsize,
  output logic [1:0]               m_axi_awburst,
  output logic                     m_axi_awvalid,
  input  logic                     m_axi_awready,
  output logic [31:0]              m_axi_wdata,
  output logic [3:0]               m_axi_wstrb,
  output logic                     m_axi_wlast,
  output logic                     m_axi_wvalid,
  input  logic                     m_axi_wready,
  input  logic [1:0]               m_axi_bresp,
  input  logic                     m_axi_bvalid,
  output logic                     m_axi_bready
);

  localparam int CW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFS_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    AR   = 3'd1,
    R    = 3'd2,
    AW   = 3'd3,
    W    = 3'd4,
    B    = 3'd5,
    RESP = 3'd6
  } state_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               cnt;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic                        err_q;
  logic [LINE_WORDS-1:0][31:0] wline;
  logic [LINE_WORDS-1:0][31:0] rline;
  logic [LINE_WORDS-1:0][31:0] rline_fill;
  logic [LINE_WORDS-1:0][31:0] resp_line;
  logic                        last_beat;
  logic                        unused_ok;

  // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign unused_ok = ^{m_axi_rresp[0], m_axi_bresp[0]};

  assign last_beat = (cnt == LAST_BEAT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    req_ready_o   = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    resp_valid_o  = 1'b0;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_nxt = req_we_i ? AW : AR;
        end
      end
      AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_nxt = R;
        end
      end
      R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat) begin
          state_nxt = RESP;
        end
      end
      AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) begin
          state_nxt = W;
        end
      end
      W: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat) begin
          state_nxt = B;
        end
      end
      B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid_o = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Refill line with the current beat merged in, so the final beat can publish the whole line at once.
  always_comb begin
    rline_fill      = rline;
    rline_fill[cnt] = m_axi_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      wline     <= '0;
      rline     <= '0;
      resp_line <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i & ~OFS_MASK;
            wline  <= req_wdata_i;
            err_q  <= 1'b0;
            cnt    <= '0;
          end
        end
        R: begin
          if (m_axi_rvalid) begin
            rline <= rline_fill;
            cnt   <= cnt + 1'b1;
            if (m_axi_rresp[1] || (m_axi_rlast != last_beat)) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              resp_line <= rline_fill;
            end
          end
        end
        W: begin
          if (m_axi_wready) begin
            cnt <= cnt + 1'b1;
          end
        end
        B: begin
          if (m_axi_bvalid && m_axi_bresp[1]) begin
            err_q <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign resp_rdata_o  = resp_line;
  assign resp_err_o    = (state == RESP) && err_q;

  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(LINE_WORDS - 1);
  assign m_axi_arsize  = 3'b010;
  assign m_axi_arburst = 2'b01;

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = 8'(LINE_WORDS - 1);
  assign m_axi_awsize  = 3'b010;
  assign m_axi_awburst = 2'b01;

  assign m_axi_wdata   = wline[cnt];
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wlast   = (state == W) && last_beat;

endmodule

// File: tb/tb_axi_line_master.sv
// Directed bench for axi_line_master with a small AXI slave memory model and programmable stalls/errors.
module tb_axi_line_master;
  localparam int LW = 4;
  localparam int AW = 32;
  localparam logic [127:0] LINE40 = 128'h00000013_00000012_00000011_00000010;
  localparam logic [127:0] WLINE  = 128'hDEADBEEF_CAFEF00D_12345678_0BADF00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           req_valid, req_ready, req_we;
  logic [AW-1:0]  req_addr;
  logic [LW*32-1:0] req_wdata, resp_rdata;
  logic           resp_valid, resp_err;
  logic [AW-1:0]  m_axi_araddr, m_axi_awaddr;
  logic [7:0]     m_axi_arlen, m_axi_awlen;
  logic [2:0]     m_axi_arsize, m_axi_awsize;
  logic [1:0]     m_axi_arburst, m_axi_awburst, m_axi_rresp, m_axi_bresp;
  logic           m_axi_arvalid, m_axi_arready, m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic           m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic           m_axi_bvalid, m_axi_bready;
  logic [31:0]    m_axi_rdata, m_axi_wdata;
  logic [3:0]     m_axi_wstrb;

  axi_line_master #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Slave knobs and observations
  logic [31:0] mem [0:255];
  int   ar_delay = 0, aw_delay = 0, r_gap = 0;
  int   r_err_beat = -1, r_last_beat = -1;
  bit   w_toggle = 0, b_err = 0;
  bit   ar_unstable = 0, w_unstable = 0, w_early = 0, strb_bad = 0;
  logic [31:0] ar_addr_seen, aw_addr_seen;
  logic [7:0]  arlen_seen, awlen_seen;
  logic [2:0]  arsize_seen, awsize_seen;
  logic [1:0]  arburst_seen, awburst_seen;
  int   wbeats = 0;
  logic [15:0] wlast_log = '0;

  // Read slave: outputs change #1 after each edge; a ready/valid set here completes on the next edge.
  initial begin : rd_slave
    int k, gap, wcnt;
    bit busy, prev_ar;
    logic [31:0] base, prev_araddr;
    k = 0; gap = 0; wcnt = 0; busy = 0; prev_ar = 0; base = '0; prev_araddr = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = '0;
        busy = 0; k = 0; gap = 0; wcnt = 0; prev_ar = 0;
        continue;
      end
      if (!busy) begin
        if (m_axi_arready) begin
          m_axi_arready = 0; busy = 1; k = 0; gap = 0; prev_ar = 0;
        end else if (m_axi_arvalid) begin
          if (prev_ar && m_axi_araddr !== prev_araddr) ar_unstable = 1;
          prev_ar = 1; prev_araddr = m_axi_araddr;
          if (wcnt >= ar_delay) begin
            m_axi_arready = 1; wcnt = 0; base = m_axi_araddr;
            ar_addr_seen = m_axi_araddr; arlen_seen = m_axi_arlen;
            arsize_seen = m_axi_arsize; arburst_seen = m_axi_arburst;
          end else wcnt++;
        end else begin
          if (prev_ar) ar_unstable = 1;
          prev_ar = 0;
        end
      end
      if (busy) begin
        m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = '0;
        if (k == LW) busy = 0;
        else if (gap < r_gap) gap++;
        else begin
          m_axi_rvalid = 1;
          m_axi_rdata  = mem[8'((base >> 2) + k)];
          m_axi_rresp  = (k == r_err_beat) ? 2'b10 : 2'b00;
          m_axi_rlast  = (k == LW - 1) || (k == r_last_beat);
          k++; gap = 0;
        end
      end
    end
  end

  initial begin : wr_slave
    int k, wcnt;
    bit aw_done, b_pend, prev_pend, wr_new;
    logic [31:0] wbase, prev_wdata;
    k = 0; wcnt = 0; aw_done = 0; b_pend = 0; prev_pend = 0; wbase = '0; prev_wdata = '0;
    m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0;
        aw_done = 0; b_pend = 0; prev_pend = 0; wcnt = 0;
        continue;
      end
      m_axi_bvalid = 0;
      if (m_axi_awready) begin
        m_axi_awready = 0; aw_done = 1; k = 0;
      end else if (m_axi_awvalid) begin
        if (wcnt >= aw_delay) begin
          m_axi_awready = 1; wcnt = 0; wbase = m_axi_awaddr;
          aw_addr_seen = m_axi_awaddr; awlen_seen = m_axi_awlen;
          awsize_seen = m_axi_awsize; awburst_seen = m_axi_awburst;
        end else wcnt++;
      end
      if (b_pend) begin
        m_axi_bvalid = 1; m_axi_bresp = b_err ? 2'b10 : 2'b00; b_pend = 0;
      end
      if (prev_pend && (!m_axi_wvalid || m_axi_wdata !== prev_wdata)) w_unstable = 1;
      wr_new = w_toggle ? !m_axi_wready : 1'b1;
      m_axi_wready = wr_new;
      if (m_axi_wvalid) begin
        if (!aw_done) w_early = 1;
        if (wr_new) begin
          mem[8'((wbase >> 2) + k)] = m_axi_wdata;
          if (k < 16) wlast_log[k] = m_axi_wlast;
          if (m_axi_wstrb !== 4'hF) strb_bad = 1;
          k++; wbeats++; prev_pend = 0;
          if (m_axi_wlast) begin b_pend = 1; aw_done = 0; end
        end else begin
          prev_pend = 1; prev_wdata = m_axi_wdata;
        end
      end else prev_pend = 0;
    end
  end

  // Issue one request and wait for its completion pulse; latency counts from the acceptance cycle.
  task automatic do_req(input string nm, input bit we, input logic [31:0] addr, input logic [127:0] wd,
                        output int lat, output logic [127:0] rd, output logic err);
    int t0;
    bit got;
    lat = -1; rd = 'x; err = 1'bx; got = 0;
    @(posedge clk); #2;
    for (int i = 0; i < 50 && !req_ready; i++) begin @(posedge clk); #2; end
    check({nm, "_req_ready"}, req_ready, 1'b1);
    req_valid = 1; req_we = we; req_addr = addr; req_wdata = wd; t0 = cyc;
    @(posedge clk); #2;
    req_valid = 0;
    for (int i = 0; i < 200; i++) begin
      if (resp_valid) begin
        got = 1; lat = cyc - t0; rd = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #2;
    end
    check({nm, "_resp_seen"}, got, 1'b1);
    if (got) begin
      @(posedge clk); #2;
      check({nm, "_pulse_once"}, resp_valid, 1'b0);
    end
  endtask

  int lat;
  logic [127:0] rd;
  logic err;
  bit found;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'(i);
    req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_ctrl", {m_axi_arvalid, m_axi_awvalid, m_axi_wvalid, m_axi_rready,
                       m_axi_bready, resp_valid, resp_err}, 7'b0);
    check("rst_rdata", resp_rdata, 128'h0);
    rst_n = 1;
    @(posedge clk); #2;
    check("rst_ready", req_ready, 1'b1);

    // Zero-wait refill
    do_req("s1", 0, 32'h40, '0, lat, rd, err);
    check("s1_lat", lat, 6);
    check("s1_data", rd, LINE40);
    check("s1_err", err, 1'b0);
    check("s1_araddr", ar_addr_seen, 32'h40);
    check("s1_arfields", {arlen_seen, arsize_seen, arburst_seen}, {8'd3, 3'b010, 2'b01});

    // Unaligned request address
    do_req("s2", 0, 32'h4C, '0, lat, rd, err);
    check("s2_araddr", ar_addr_seen, 32'h40);
    check("s2_data", rd, LINE40);

    // Write-back then read-back
    wbeats = 0; wlast_log = '0;
    do_req("s3w", 1, 32'h80, WLINE, lat, rd, err);
    check("s3_lat", lat, 7);
    check("s3_err", err, 1'b0);
    check("s3_beats", wbeats, 4);
    check("s3_wlast", wlast_log, 16'b1000);
    check("s3_awfields", {aw_addr_seen, awlen_seen, awsize_seen, awburst_seen},
          {32'h80, 8'd3, 3'b010, 2'b01});
    check("s3_mem", {mem[35], mem[34], mem[33], mem[32]}, WLINE);
    check("s3_strb", strb_bad, 1'b0);
    check("s3_w_before_aw", w_early, 1'b0);
    do_req("s3r", 0, 32'h80, '0, lat, rd, err);
    check("s3_readback", rd, WLINE);

    // Backpressure on every channel
    ar_delay = 5; r_gap = 2; aw_delay = 3; w_toggle = 1;
    do_req("s4r", 0, 32'h40, '0, lat, rd, err);
    check("s4_rdata", rd, LINE40);
    check("s4_ar_stable", ar_unstable, 1'b0);
    wbeats = 0; wlast_log = '0;
    do_req("s4w", 1, 32'hC0, WLINE, lat, rd, err);
    check("s4_beats", wbeats, 4);
    check("s4_wlast", wlast_log, 16'b1000);
    check("s4_mem", {mem[51], mem[50], mem[49], mem[48]}, WLINE);
    check("s4_w_stable", w_unstable, 1'b0);
    check("s4_w_before_aw", w_early, 1'b0);
    do_req("s4rb", 0, 32'hC0, '0, lat, rd, err);
    check("s4_readback", rd, WLINE);
    ar_delay = 0; r_gap = 0; aw_delay = 0; w_toggle = 0;

    // Error reporting without aborting the burst
    r_err_beat = 2;
    do_req("s5a", 0, 32'h40, '0, lat, rd, err);
    check("s5_slverr", err, 1'b1);
    check("s5_slverr_data", rd, LINE40);
    r_err_beat = -1; r_last_beat = 1;
    do_req("s5b", 0, 32'h40, '0, lat, rd, err);
    check("s5_rlast_err", err, 1'b1);
    check("s5_rlast_data", rd, LINE40);
    r_last_beat = -1;
    do_req("s5c", 0, 32'h40, '0, lat, rd, err);
    check("s5_clean_err", err, 1'b0);
    b_err = 1;
    do_req("s5d", 1, 32'hC0, WLINE, lat, rd, err);
    check("s5_bresp_err", err, 1'b1);
    b_err = 0;
    do_req("s5e", 1, 32'hC0, WLINE, lat, rd, err);
    check("s5_bresp_clean", err, 1'b0);
    check("s5_refill_kept", rd, LINE40);

    // Reset asserted during W beat 2
    @(posedge clk); #2;
    req_valid = 1; req_we = 1; req_addr = 32'h100; req_wdata = WLINE;
    @(posedge clk); #2;
    req_valid = 0;
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (m_axi_wvalid && m_axi_wdata == 32'hCAFEF00D) begin found = 1; break; end
      @(posedge clk); #2;
    end
    check("s6_reached_beat2", found, 1'b1);
    #1 rst_n = 0;
    #1;
    check("s6_valids_drop", {m_axi_wvalid, m_axi_awvalid, m_axi_arvalid, m_axi_rready, m_axi_bready},
          5'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #2;
    check("s6_ready", req_ready, 1'b1);
    do_req("s6r", 0, 32'h40, '0, lat, rd, err);
    check("s6_data", rd, LINE40);
    check("s6_err", err, 1'b0);
    check("s6_lat", lat, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_line_master.md
Name: axi_line_master

Overview:
AXI4 burst initiator that moves whole cache lines between a cache controller and an AXI slave memory. Each request is either a line refill, issued as an INCR read burst, or a line write-back, issued as an INCR write burst. It sits between the simple/n-way cache and the instruction/data AXI memory ports of the Kuuga simulation block design. It is the master-side counterpart of the AXI VIP slave memory agents.

Parameters:
LINE_WORDS, 4, 32-bit words per cache line; power of two, range 2..16.
ADDR_WIDTH, 32, AXI address width.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid_i  in  1  line request valid
req_ready_o  out  1  request accepted when high together with req_valid_i
req_we_i  in  1  1 = write-back, 0 = refill
req_addr_i  in  ADDR_WIDTH  line address; low log2(LINE_WORDS*4) bits ignored
req_wdata_i  in  LINE_WORDS*32  write-back line; word 0 in LSBs
resp_valid_o  out  1  one-cycle completion pulse
resp_rdata_o  out  LINE_WORDS*32  refill line; word 0 in LSBs
resp_err_o  out  1  valid with resp_valid_o; any non-OKAY response or RLAST mismatch
m_axi_araddr/arlen/arsize/arburst/arvalid  out  ADDR_WIDTH/8/3/2/1  read address channel
m_axi_arready  in  1
m_axi_rdata/rresp/rlast/rvalid  in  32/2/1/1  read data channel
m_axi_rready  out  1
m_axi_awaddr/awlen/awsize/awburst/awvalid  out  ADDR_WIDTH/8/3/2/1  write address channel
m_axi_awready  in  1
m_axi_wdata/wstrb/wlast/wvalid  out  32/4/1/1  write data channel
m_axi_wready  in  1
m_axi_bresp/bvalid  in  2/1  write response channel
m_axi_bready  out  1

Behaviour:
- Reset (async assert, sync deassert): state IDLE. All valid/ready outputs, resp_err_o, resp_rdata_o and the beat counter are 0. req_ready_o is 1 once out of reset.
- States: IDLE, AR, R, AW, W, B, RESP.
- IDLE: req_ready_o=1 only in this state. On handshake, latch the aligned address (low bits cleared), req_wdata_i and req_we_i. Clear the error flag and beat counter. Next state is AW if we, else AR.
- Fixed fields: arlen/awlen = LINE_WORDS-1; arsize/awsize = 3'b010; arburst/awburst = 2'b01 (INCR); wstrb = 4'hF.
- AR: arvalid=1 with araddr stable until arready. On handshake go to R.
- R: rready=1. Each rvalid beat stores rdata into word[counter], then counter+1.
  - rresp[1]=1 sets the error flag.
  - rlast asserted at counter != LINE_WORDS-1, or deasserted at counter == LINE_WORDS-1, sets the error flag.
  - The burst ends on the beat with counter == LINE_WORDS-1; go to RESP.
- AW: awvalid=1 until awready, then go to W. W is never issued before the AW handshake.
- W: wvalid=1, wdata = latched word[counter], wlast = (counter == LINE_WORDS-1). Counter advances on each wready. wvalid and wdata stay stable while wready=0. After the last beat go to B.
- B: bready=1. On bvalid, bresp[1] sets the error flag; go to RESP.
- RESP: resp_valid_o=1 for exactly one cycle, with resp_err_o = error flag. resp_rdata_o holds the refill line and stays stable until the next refill completes. Return to IDLE.
- Latency with zero-wait slave:
  - Refill: acceptance at cycle T, resp_valid_o at T+LINE_WORDS+2.
  - Write-back: resp_valid_o at T+LINE_WORDS+3.
- Only one transaction is outstanding. A new request is accepted no earlier than the cycle after the RESP pulse.
- An error never aborts a burst; all beats always complete.
- Reset mid-burst: all AXI valids/readies drop to 0 immediately and the state returns to IDLE. The slave shares rst_n.
- Address wrap: INCR bursts never cross 4 KB, because the address is line-aligned and LINE_WORDS*4 ≤ 64.

Test Plan:
1. Zero-wait refill: VIP memory preloaded with word i = i at byte address 4i; refill at 0x40 with LINE_WORDS=4 -> araddr=0x40, arlen=3, resp_rdata_o=0x00000013_00000012_00000011_00000010, resp_err_o=0, resp_valid_o at T+6.
2. Unaligned refill: req_addr_i=0x4C -> araddr=0x40 and the same line as scenario 1.
3. Write-back then read-back: write line {0xDEADBEEF, 0xCAFEF00D, 0x12345678, 0x0BADF00D} (word 3..0) to 0x80 -> 4 W beats with wlast on beat 3 only, bresp=OKAY, resp_valid_o at T+7; a subsequent refill at 0x80 returns the identical line.
4. Backpressure: arready delayed 5 cycles, rvalid gaps of 2 cycles, wready toggling -> address and data held stable while waiting, no beat lost or duplicated, same data as scenarios 1 and 3.
5. Error: slave returns SLVERR on read beat 2, then a separate case with rlast on beat 1 -> all 4 beats consumed, resp_err_o=1 on the pulse; the next clean request gives resp_err_o=0.
6. Reset mid-burst: rst_n low during W beat 2 -> wvalid/awvalid/arvalid = 0 in the same cycle, req_ready_o=1 after release, and the following refill completes correctly.
